prescaler_multi: RTL and testbench
==================================

// Module: prescaler_multi
// PURPOSE
//  Multi-channel clock-enable generator for the logic analyzer sampling path; successor to the
//  single-channel prescaler. Each channel divides clk by a runtime factor and emits 1-cycle ce pulses.
//  Channels run continuously or in bursts of N pulses. Factor changes are shadowed and take effect
//  only at terminal count, so a period is never truncated.
// PARAMETERS
//  CHANNELS  4   number of independent divider channels
//  WIDTH     16  width of the divide factor and the period counter
//  BURST_W   16  width of the burst length and the remaining-pulse counter
// PORTS
//  clk        in   1               system clock; all logic on rising edge
//  rst        in   1               synchronous, active-high reset
//  factor     in   CHANNELS*WIDTH  divide factor, channel i at [i*WIDTH +: WIDTH]
//  factor_wr  in   CHANNELS        write strobe: factor slice i -> shadow register i
//  mode       in   CHANNELS        0 = continuous, 1 = burst; sampled on start
//  burst_len  in   BURST_W         pulse count for burst mode, shared; sampled on start
//  start      in   CHANNELS        start/restart channel i (1-cycle strobe)
//  stop       in   CHANNELS        abort channel i (1-cycle strobe)
//  ce         out  CHANNELS        registered clock-enable, 1 cycle high per period
//  busy       out  CHANNELS        channel in RUN
//  done       out  CHANNELS        1-cycle pulse with the last ce of a burst
// BEHAVIOUR
//  Reset: ce = 0, busy = 0, done = 0; every channel goes to IDLE; counters = 0; shadow = 1; active = 1.
//  Factor: an effective factor of 0 is treated as 1. F = 1 gives ce every cycle.
//  Burst length: an effective burst_len of 0 is treated as 1.
//  Per-channel FSM states are IDLE and RUN. Registers: shadow, active, cnt, rem, mode_r.
//  IDLE:
//   - ce = 0 and busy = 0.
//   - factor_wr updates the shadow register only.
//  start at edge E0 (from IDLE or RUN):
//   - cnt <= 0; active <= shadow, or the factor input if factor_wr is high in the same cycle.
//   - rem <= burst_len; mode_r <= mode; state <= RUN; busy = 1 from E0.
//  RUN:
//   - While cnt < active-1: cnt increments and ce <= 0.
//   - At terminal count (cnt == active-1): ce <= 1, cnt <= 0, active <= shadow (reload).
//   - The first ce is high in the cycle after edge E0+F, so ce has period F and is aligned to start.
//  Burst:
//   - Each ce decrements rem.
//   - The ce issued when rem == 1 also drives done <= 1; state <= IDLE and busy drops on that same edge.
//  Continuous: rem is ignored; the channel runs until stop or rst.
//  stop in RUN:
//   - IDLE on the next edge; ce <= 0; done is not asserted; a pending terminal count is dropped.
//  Simultaneous events:
//   - stop and start together: stop wins.
//   - start in RUN: clean restart, no ce in that cycle.
//   - factor_wr at terminal count: the new value is loaded into active.
//  stop in IDLE is ignored.
//  rst mid-burst: outputs are 0 on the next edge; done is not asserted.
//  Counter arithmetic: WIDTH-bit unsigned, no wrap, because cnt never exceeds active-1.
//  Channels are fully independent; ce pulses of different channels may coincide.
// TESTING
//  1. Ch0: factor 4, mode 0, start @E0 -> ce0 high at E4, E8, E12...; busy0 = 1; other channels stay 0.
//  2. Ch1: factor 3, burst_len 5, start -> exactly 5 ce pulses 3 cycles apart; done1 with the 5th;
//     then busy1 = 0.
//  3. Ch0 running F = 4; write factor 2 mid-period -> current period completes at 4; following periods are 2.
//  4. Factor 0 and factor 1 -> ce every cycle; burst_len 0 -> one pulse plus done.
//  5. start + stop same cycle -> stays IDLE; stop mid-burst -> no done; start in RUN restarts count.
//  6. rst asserted mid-run on all channels -> ce/busy/done = 0 next edge; shadow = 1 after release.

Source files
------------

// File: rtl/prescaler_multi.sv
// Multi-channel clock-enable generator: each channel divides clk by a shadowed
// runtime factor and emits 1-cycle ce pulses, continuously or in bursts of N.

module prescaler_lane #(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   factor,
  input  logic               factor_wr,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  output logic               ce,
  output logic               busy,
  output logic               done
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   shadow_q, shadow_d;
  logic [WIDTH-1:0]   active_q, active_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               mode_q, mode_d;
  logic               ce_q, ce_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   fac_eff, next_active;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    mode_d   = mode_q;
    ce_d     = 1'b0;
    done_d   = 1'b0;
    // Factors are stored already normalised, so active is never 0 and active-1 never wraps
    fac_eff     = (factor == '0) ? WIDTH'(1) : factor;
    next_active = factor_wr ? fac_eff : shadow_q;
    if (factor_wr) shadow_d = fac_eff;

    if (stop) begin
      state_d = S_IDLE;
    end else if (start) begin
      state_d  = S_RUN;
      cnt_d    = '0;
      active_d = next_active;
      rem_d    = (burst_len == '0) ? BURST_W'(1) : burst_len;
      mode_d   = mode;
    end else if (state_q == S_RUN) begin
      if (cnt_q == active_q - WIDTH'(1)) begin
        ce_d     = 1'b1;
        cnt_d    = '0;
        active_d = next_active;
        if (mode_q) begin
          if (rem_q == BURST_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            rem_d = rem_q - BURST_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shadow_q <= WIDTH'(1);
      active_q <= WIDTH'(1);
      cnt_q    <= '0;
      rem_q    <= '0;
      mode_q   <= 1'b0;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      ce_q     <= ce_d;
      done_q   <= done_d;
    end
  end

  assign ce   = ce_q;
  assign done = done_q;
  assign busy = (state_q == S_RUN);
endmodule

module prescaler_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int BURST_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] factor,
  input  logic [CHANNELS-1:0]       factor_wr,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [BURST_W-1:0]        burst_len,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    prescaler_lane #(.WIDTH(WIDTH), .BURST_W(BURST_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .factor    (factor[i*WIDTH +: WIDTH]),
      .factor_wr (factor_wr[i]),
      .mode      (mode[i]),
      .burst_len (burst_len),
      .start     (start[i]),
      .stop      (stop[i]),
      .ce        (ce[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end
endmodule

// File: tb/tb_prescaler_multi.sv
// Scoreboard bench for prescaler_multi: a countdown reference model predicts
// ce/busy/done per edge; a negedge monitor pops and compares.

module tb_prescaler_multi;
  localparam int CH = 4;
  localparam int W  = 16;
  localparam int BW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   factor;
  logic [CH-1:0]     factor_wr, mode, start, stop;
  logic [BW-1:0]     burst_len;
  logic [CH-1:0]     ce, busy, done;

  typedef struct packed {
    logic [CH-1:0] ce;
    logic [CH-1:0] busy;
    logic [CH-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: cycles remaining until the next ce, pulses left in burst
  int unsigned m_run[CH], m_cd[CH], m_shadow[CH], m_rem[CH], m_burst[CH];

  prescaler_multi #(.CHANNELS(CH), .WIDTH(W), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .factor(factor), .factor_wr(factor_wr), .mode(mode),
    .burst_len(burst_len), .start(start), .stop(stop),
    .ce(ce), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int unsigned eff(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_step();
    exp_t e;
    int unsigned fe, nxt;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (rst) begin
        m_run[c] = 0; m_cd[c] = 0; m_shadow[c] = 1; m_rem[c] = 0; m_burst[c] = 0;
      end else begin
        fe  = eff(int'(factor[c*W +: W]));
        nxt = factor_wr[c] ? fe : m_shadow[c];
        if (stop[c]) begin
          m_run[c] = 0;
        end else if (start[c]) begin
          m_run[c] = 1; m_cd[c] = nxt; m_rem[c] = eff(int'(burst_len)); m_burst[c] = mode[c];
        end else if (m_run[c] != 0) begin
          m_cd[c]--;
          if (m_cd[c] == 0) begin
            e.ce[c] = 1'b1;
            m_cd[c] = nxt;
            if (m_burst[c] != 0) begin
              m_rem[c]--;
              if (m_rem[c] == 0) begin
                e.done[c] = 1'b1;
                m_run[c]  = 0;
              end
            end
          end
        end
        if (factor_wr[c]) m_shadow[c] = fe;
      end
      e.busy[c] = (m_run[c] != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    start = '0; stop = '0; factor_wr = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_fac(input int c, input int unsigned v);
    factor[c*W +: W] = W'(v);
    factor_wr[c] = 1'b1;
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ce", ce, e.ce);
      check("busy", busy, e.busy);
      check("done", done, e.done);
    end
  end

  initial begin
    rst = 1'b1; factor = '0; factor_wr = '0; mode = '0; start = '0; stop = '0; burst_len = '0;
    ticks(2);
    rst = 1'b0;
    // 1: ch0 continuous F=4
    set_fac(0, 4); start[0] = 1'b1; mode[0] = 1'b0;
    ticks(13);
    // 2: ch1 burst of 5 at F=3
    set_fac(1, 3); mode[1] = 1'b1; burst_len = 5; start[1] = 1'b1;
    ticks(20);
    // 3: ch0 factor change mid-period
    ticks(1); set_fac(0, 2); ticks(10);
    // 4: factor 0 / 1 continuous, burst_len 0
    set_fac(2, 0); set_fac(3, 1); mode[3:2] = 2'b00; start[3:2] = 2'b11; ticks(4);
    set_fac(1, 2); mode[1] = 1'b1; burst_len = 0; start[1] = 1'b1; ticks(6);
    // 5: start+stop together, stop mid-burst, restart in RUN
    stop = '1; ticks(2);
    start[1] = 1'b1; stop[1] = 1'b1; ticks(3);
    set_fac(1, 3); burst_len = 4; start[1] = 1'b1; ticks(5);
    stop[1] = 1'b1; ticks(3);
    set_fac(0, 5); start[0] = 1'b1; ticks(3); start[0] = 1'b1; ticks(8);
    // 6: reset mid-run on all channels, shadow returns to 1
    for (int c = 0; c < CH; c++) set_fac(c, c + 3);
    mode = 4'b1010; burst_len = 3; start = '1; ticks(5);
    rst = 1'b1; ticks(1); rst = 1'b0;
    mode = '0; start = '1; ticks(4); stop = '1; ticks(2);
    // Random phase
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        factor[c*W +: W] = W'($urandom_range(0, 6));
        factor_wr[c] = ($urandom_range(0, 7) == 0);
        start[c]     = ($urandom_range(0, 15) == 0);
        stop[c]      = ($urandom_range(0, 31) == 0);
        mode[c]      = $urandom_range(0, 1) != 0;
      end
      burst_len = BW'($urandom_range(0, 5));
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(2);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
